load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the unified word-wide instruction/data memory port (address, write data, write, read, read data).
- Sits between the core's execute stage and the memory.
- Turns byte, halfword and word loads/stores (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory transactions.
- Sub-word stores use read-modify-write, because the memory has no byte enables. The block also flags misaligned accesses.

Parameters:
- XLEN, 32: data and address width.
- MEM_LAT, 0: extra wait cycles before the read data is sampled. 0 matches today's combinational-read memory.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iReq  in  1  start request; sampled only in IDLE
- iWrite  in  1  1 = store, 0 = load
- iFunct3  in  3  RV32I funct3 of the load/store
- iAddress  in  XLEN  byte address
- iWData  in  XLEN  store data (rs2)
- oRData  out  XLEN  load result, sign- or zero-extended; valid while oDone
- oDone  out  1  one-cycle completion pulse
- oBusy  out  1  high in every state except IDLE
- oMisaligned  out  1  valid with oDone; access rejected
- oMemAddress  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- oMemWData  out  XLEN  write data to memory
- oMemWrite  out  1  memory write strobe
- oMemRead  out  1  memory read enable
- iMemRData  in  XLEN  memory read data

Behaviour:
- Reset: state=IDLE. All outputs 0, including oRData, oMemAddress and oMemWData. oMemWrite is gated by !reset, so no write commits on an edge where reset is high, even from WRITE.
- Encoding: little-endian. Byte k = addr[1:0] occupies bits [8k+7:8k]; halfword at addr[1] occupies bits [16*addr[1]+15:16*addr[1]].
- States: IDLE, READ, WRITE, DONE, ERR. All memory outputs are Moore, decoded from state and latched request registers.
- IDLE: when iReq=1, latch iWrite, iFunct3, iAddress and iWData.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. Misaligned goes to ERR.
  - A load, SB or SH goes to READ. SW goes to WRITE.
  - Unsupported funct3 (011, 11x, or store with 1xx) goes to ERR.
- READ: oMemRead=1 and oMemAddress driven, held for 1+MEM_LAT cycles using a wait counter. iMemRData is captured into a word register on the last cycle.
  - Load goes to DONE.
  - SB/SH goes to WRITE.
- WRITE: oMemWrite=1 for exactly one cycle.
  - oMemWData = iWData for SW.
  - For SB/SH, oMemWData = captured word with the addressed byte or halfword replaced by iWData[7:0] or [15:0].
  - Then go to DONE.
- DONE: oDone=1 for one cycle. Then go to IDLE.
  - oRData = extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - Stores drive oRData=0.
- ERR: oDone=1 and oMisaligned=1 for one cycle, oRData=0, no oMemRead/oMemWrite ever asserted. Then go to IDLE.
- Latency, counted in cycles after the accepting edge (MEM_LAT=0):
  - Loads: oDone in cycle 2.
  - SW: oDone in cycle 2.
  - SB/SH: oDone in cycle 3.
  - ERR: oDone in cycle 1.
  - Add MEM_LAT for any path that passes through READ.
- iReq while oBusy is ignored, not queued. The requester holds or re-issues it.
- A new request is accepted only in IDLE, never in DONE or ERR.
- Reset mid-operation: abort immediately, discard latched data, go to IDLE. No partial write is performed.
- oMemRead and oMemWrite are never both 1 in the same cycle.

Decomposition:
- Shared in params.v:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encodings.
  - DATA/TEXT base constants, for benches only.
- Sub-module mem_lane_align (combinational), two functions:
  - Extract: given word, addr[1:0] and funct3, produce the extended load value.
  - Merge: given old word, store data, addr[1:0] and funct3, produce the new word.
- The FSM, wait counter and request registers stay in load_store_unit.

Test Plan:
- Setup: word at 0x10010004 = 0x80FF7F01.
  - LB 0x10010007 gives oRData=0xFFFFFF80 in cycle 2.
  - LBU at the same address gives 0x00000080.
  - LB 0x10010004 gives 0x00000001.
- LH 0x10010006 gives 0xFFFF80FF; LHU gives 0x000080FF. LW 0x10010004 gives 0x80FF7F01. Exactly one oMemRead cycle each.
- SB iWData=0x123456AB to 0x10010005:
  - One READ cycle, then one WRITE cycle with oMemWData=0x80FFAB01.
  - The word then reads 0x80FFAB01. oDone in cycle 3.
- SW 0x10010002, or LH 0x10010001: oDone=1 and oMisaligned=1 in cycle 1. oMemRead and oMemWrite stay 0 throughout. Memory is unchanged.
- SH 0xBEEF to 0x10010004 with reset asserted during WRITE: no write edge, word still 0x80FF7F01, all outputs 0 the next cycle, then a fresh LW succeeds.
- MEM_LAT=2, LW 0x10010004:
  - oMemRead is held 3 cycles and oDone comes in cycle 4.
  - An iReq pulse in cycle 2 is ignored.
  - No second transaction starts.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, FSM states and decode helpers
// Contents:
//   F3_*            RV32I load/store funct3 encodings
//   state_e         load_store_unit FSM states
//   DATA/TEXT_BASE  memory map bases (used by benches only)
//   f3_supported    funct3 legal for the given direction
//   f3_misaligned   address not naturally aligned for the access size
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Unsigned variants exist only for loads.
  function automatic logic f3_supported(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_mem_lane_align.sv
// rtl/load_store_unit_mem_lane_align.sv - little-endian lane extract and merge
// Ports:
//   word_i     memory word (captured read data)
//   data_i     store data (rs2)
//   addr_lo_i  byte offset within the word
//   funct3_i   RV32I funct3
//   load_o     extracted, sign/zero-extended load value
//   merge_o    word to write back: data_i for SW, else word_i with one lane replaced
module mem_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o
);

  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [4:0]      byte_sh;
  logic [4:0]      half_sh;
  logic [XLEN-1:0] byte_mask;
  logic [XLEN-1:0] half_mask;

  assign byte_sh   = {addr_lo_i, 3'b000};
  assign half_sh   = {addr_lo_i[1], 4'b0000};
  assign byte_mask = XLEN'(8'hFF) << byte_sh;
  assign half_mask = XLEN'(16'hFFFF) << half_sh;
  assign half_v    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    byte_v = word_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
  end

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   load_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    load_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   load_o = {{(XLEN-16){1'b0}}, half_v};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = data_i;
    case (funct3_i)
      F3_B:    merge_o = (word_i & ~byte_mask) | ((XLEN'(data_i[7:0]) << byte_sh) & byte_mask);
      F3_H:    merge_o = (word_i & ~half_mask) | ((XLEN'(data_i[15:0]) << half_sh) & half_mask);
      default: merge_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for a word-wide memory without byte enables
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   iReq..iWData          request (accepted in IDLE only)
//   oRData, oDone         load result, one-cycle completion pulse
//   oBusy, oMisaligned    not-IDLE, rejected-access flag (with oDone)
//   oMemAddress..iMemRData word-aligned memory port
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iReq,
  input  logic            iWrite,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iAddress,
  input  logic [XLEN-1:0] iWData,
  output logic [XLEN-1:0] oRData,
  output logic            oDone,
  output logic            oBusy,
  output logic            oMisaligned,
  output logic [XLEN-1:0] oMemAddress,
  output logic [XLEN-1:0] oMemWData,
  output logic            oMemWrite,
  output logic            oMemRead,
  input  logic [XLEN-1:0] iMemRData
);

  localparam int WCW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [WCW-1:0]  wait_q, wait_d;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merge_val;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .word_i    (word_q),
    .data_i    (wdata_q),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .load_o    (load_val),
    .merge_o   (merge_val)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    wait_d   = wait_q;
    case (state_q)
      S_IDLE: begin
        if (iReq) begin
          write_d  = iWrite;
          funct3_d = iFunct3;
          addr_d   = iAddress;
          wdata_d  = iWData;
          wait_d   = '0;
          if (!f3_supported(iWrite, iFunct3) || f3_misaligned(iFunct3, iAddress[1:0]))
            state_d = S_ERR;
          else if (iWrite && (iFunct3 == F3_W))
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        // Hold the read for 1+MEM_LAT cycles; sample data only on the last one.
        if (wait_q == WCW'(MEM_LAT)) begin
          word_d  = iMemRData;
          state_d = write_q ? S_WRITE : S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; the write strobe is additionally masked by reset so an
  // aborted read-modify-write never commits on the reset edge.
  assign oBusy       = (state_q != S_IDLE);
  assign oDone       = (state_q == S_DONE) || (state_q == S_ERR);
  assign oMisaligned = (state_q == S_ERR);
  assign oMemRead    = (state_q == S_READ);
  assign oMemWrite   = (state_q == S_WRITE) && !reset;
  assign oMemAddress = ((state_q == S_READ) || (state_q == S_WRITE)) ?
                       {addr_q[XLEN-1:2], 2'b00} : '0;
  assign oMemWData   = (state_q == S_WRITE) ? merge_val : '0;
  assign oRData      = ((state_q == S_DONE) && !write_q) ? load_val : '0;

endmodule
